// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - operation encodings driven on the op port
//   - FSM state encodings (also visible on the dbg_state port)
//   - default operand width and iteration-counter width
// Optional feature macro: MULDIV_SIGNED_EN (see exe_muldiv).
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: sign handling for signed mult/div.
//   Start side : converts operands to magnitudes and reports their signs.
//   Result side: negates the unsigned iteration result as required.
// Ports:
//   sign_en_i            op[1]; 1 selects signed interpretation
//   a_i, b_i             raw operands
//   a_mag_o, b_mag_o     operand magnitudes (raw values when unsigned)
//   a_neg_o, b_neg_o     operand was negative (signed only)
//   is_div_i             in-flight operation is a divide
//   neg_a_i, neg_b_i     operand signs captured at start
//   raw_hi_i, raw_lo_i   unsigned result from the iteration datapath
//   hi_o, lo_o           sign-corrected result
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             sign_en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_mag_o,
    output logic [WIDTH-1:0] b_mag_o,
    output logic             a_neg_o,
    output logic             b_neg_o,
    input  logic             is_div_i,
    input  logic             neg_a_i,
    input  logic             neg_b_i,
    input  logic [WIDTH-1:0] raw_hi_i,
    input  logic [WIDTH-1:0] raw_lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg_o = sign_en_i & a_i[WIDTH-1];
    assign b_neg_o = sign_en_i & b_i[WIDTH-1];
    assign a_mag_o = a_neg_o ? -a_i : a_i;
    assign b_mag_o = b_neg_o ? -b_i : b_i;

    assign prod     = {raw_hi_i, raw_lo_i};
    assign prod_neg = -prod;

    // Remainder follows the dividend's sign; quotient and product follow
    // the sign difference. -2^(W-1)/-1 needs no special case: the unsigned
    // quotient 2^(W-1) is already the required bit pattern.
    always_comb begin
        hi_o = raw_hi_i;
        lo_o = raw_lo_i;
        if (is_div_i) begin
            hi_o = neg_a_i ? -raw_hi_i : raw_hi_i;
            lo_o = (neg_a_i ^ neg_b_i) ? -raw_lo_i : raw_lo_i;
        end else if (neg_a_i ^ neg_b_i) begin
            {hi_o, lo_o} = prod_neg;
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative multiply/divide unit with architectural HI/LO.
//   Multiply: shift-add, divide: restoring; WIDTH iterations either way.
//   Divide by zero completes at once with hi=eqa, lo=all ones.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start, op           begin an operation (accepted in IDLE/DONE only)
//   eqa, eqb            operands A and B
//   mthi, mtlo          write eqa to HI / LO (ignored while busy)
//   abort               pipeline flush; cancels in-flight op, suppresses start
//   hi, lo              HI/LO registers
//   busy                operation in progress (stall request)
//   done                one-cycle pulse when HI/LO first show a new result
//   dbg_state           current FSM state
// Handshake: start is taken on any edge where state is IDLE or DONE and abort
// is low; the result is valid in the cycle done is high, no back-pressure.
// Macro MULDIV_SIGNED_EN: op[1]=1 selects signed mult/div; when undefined
// op[1] is ignored.
module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] eqa,
    input  logic [WIDTH-1:0] eqb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output muldiv_state_e    dbg_state
);

    muldiv_state_e      state_q;
    logic [CNT_W-1:0]   cnt_q;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   raw_hi, raw_lo;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;  // WIDTH+1-bit partial remainder
    logic [WIDTH:0]     div_diff;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_d;
    logic               unused_rem_msb;

    // One iteration of either algorithm.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        div_ge    = (div_trial >= {1'b0, opb_q});
        div_rem   = div_ge ? div_diff : div_trial;
        if (is_div_q) begin
            acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // After a restoring step the remainder is below the divisor, so its MSB is zero.
    assign unused_rem_msb = div_rem[WIDTH];

    assign raw_hi = acc_d[2*WIDTH-1:WIDTH];
    assign raw_lo = acc_d[WIDTH-1:0];

`ifdef MULDIV_SIGNED_EN
    muldiv_signfix #(
        .WIDTH (WIDTH)
    ) u_signfix (
        .sign_en_i (op[1]),
        .a_i       (eqa),
        .b_i       (eqb),
        .a_mag_o   (a_mag),
        .b_mag_o   (b_mag),
        .a_neg_o   (a_neg),
        .b_neg_o   (b_neg),
        .is_div_i  (is_div_q),
        .neg_a_i   (neg_a_q),
        .neg_b_i   (neg_b_q),
        .raw_hi_i  (raw_hi),
        .raw_lo_i  (raw_lo),
        .hi_o      (fix_hi),
        .lo_o      (fix_lo)
    );
`else
    logic unused_sign;
    assign a_mag       = eqa;
    assign b_mag       = eqb;
    assign a_neg       = 1'b0;
    assign b_neg       = 1'b0;
    assign fix_hi      = raw_hi;
    assign fix_lo      = raw_lo;
    assign unused_sign = op[1] ^ neg_a_q ^ neg_b_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (mthi) hi_q <= eqa;
                    if (mtlo) lo_q <= eqa;
                    if (start && !abort) begin
                        if (op[0] && (eqb == '0)) begin
                            // Divide by zero: result is known now, skip BUSY.
                            state_q <= ST_DONE;
                            hi_q    <= eqa;
                            lo_q    <= {WIDTH{1'b1}};
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_BUSY;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= op[0];
                            neg_a_q  <= a_neg;
                            neg_b_q  <= b_neg;
                            acc_q    <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                            opb_q    <= op[0] ? b_mag : a_mag;
                        end
                    end
                end
                ST_BUSY: begin
                    if (abort) begin
                        // Flush wins over completion; HI/LO are untouched.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            hi_q    <= fix_hi;
                            lo_q    <= fix_lo;
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed bench for exe_muldiv with a result scoreboard.
module tb_exe_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op    = 2'b00;
    logic [W-1:0]  eqa   = '0;
    logic [W-1:0]  eqb   = '0;
    logic          mthi  = 1'b0;
    logic          mtlo  = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  hi, lo;
    logic          busy, done;
    muldiv_state_e dbg_state;

    always #5 clock = ~clock;

    exe_muldiv #(.WIDTH(W), .CNT_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .eqa       (eqa),
        .eqb       (eqb),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .abort     (abort),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_expected", {63'd0, done}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, mon_exp[63:32]});
                check("result_lo", {32'd0, lo}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [2*W-1:0] e);
        @(posedge clock); #1;
        start = 1'b1; op = o; eqa = a; eqb = b;
        if (push) exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Counts cycles (and busy cycles) after the start edge until done is seen.
    task automatic wait_done(input int max_cyc, output int cyc, output int bcyc);
        logic seen;
        seen = 1'b0; cyc = 0; bcyc = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
            if (busy === 1'b1) bcyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic write_hilo(input logic [W-1:0] hv, input logic [W-1:0] lv);
        @(posedge clock); #1; mthi = 1'b1; eqa = hv;
        @(posedge clock); #1; mthi = 1'b0; mtlo = 1'b1; eqa = lv;
        @(posedge clock); #1; mtlo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c, b;
        logic dseen;

        repeat (3) @(posedge clock);
        #1;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b1;

        // multu max*max
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_done(40, c, b);
        check("mul_latency", 64'(c), 64'd33);
        check("mul_busy_cycles", 64'(b), 64'd32);

        // divu 100/7
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        wait_done(40, c, b);
        check("div_latency", 64'(c), 64'd33);

        // divu by zero
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFF_FFFF});
        wait_done(5, c, b);
        check("div0_latency", 64'(c), 64'd1);
        check("div0_busy_cycles", 64'(b), 64'd0);

        // mthi / mtlo then aborted multiply
        write_hilo(32'h0000_AAAA, 32'h0000_5555);
        @(negedge clock);
        check("mthi_value", {32'd0, hi}, 64'h0000_AAAA);
        check("mtlo_value", {32'd0, lo}, 64'h0000_5555);
        issue(OP_MULTU, 32'd3, 32'd4, 1'b0, '0);
        repeat (10) @(negedge clock);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_hi_kept", {32'd0, hi}, 64'h0000_AAAA);
        check("abort_lo_kept", {32'd0, lo}, 64'h0000_5555);
        dseen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) dseen = 1'b1;
        end
        check("abort_no_done", {63'd0, dseen}, 64'd0);

        // back-to-back: second start issued during the DONE cycle
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
        wait_done(40, c, b);
        check("b2b_first_latency", 64'(c), 64'd33);
        start = 1'b1; op = OP_DIVU; eqa = 32'd100; eqb = 32'd7;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_busy_no_gap", {63'd0, busy}, 64'd1);
        check("b2b_state", 64'(dbg_state), 64'(ST_BUSY));
        mtlo = 1'b1; eqa = 32'h1234;
        @(posedge clock); #1;
        mtlo = 1'b0;
        @(negedge clock);
        check("mtlo_ignored_busy", {32'd0, lo}, 64'd42);
        wait_done(40, c, b);
        check("b2b_second_latency", 64'(c), 64'd31);

        // asynchronous reset mid-divide, then a fresh divide
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0);
        repeat (16) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3});
        wait_done(40, c, b);

`ifdef MULDIV_SIGNED_EN
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_done(40, c, b);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done(40, c, b);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
        wait_done(40, c, b);
`else
        // op[1] ignored: mult/div behave as multu/divu
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, {32'h0000_0004, 32'hFFFF_FFF1});
        wait_done(40, c, b);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'h0000_0001, 32'h7FFF_FFFC});
        wait_done(40, c, b);
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
